fetch_stage_buffered: RTL and testbench

Parametrised successor to the pipeline's fetch stage: owns the PC, issues instruction requests to a variable-latency instruction memory over a valid/ready request channel, and buffers returned instructions in a small in-order fetch queue feeding decode. Adds decode stall (back-pressure), branch redirect with discard of in-flight responses, and a configurable reset vector, so decode sees a valid-qualified instruction stream. Sits between the imem port and the decode stage of the core.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 55 +++++
 rtl/fetch_stage_buffered.sv | 121 ++++++++++++
 tb/tb_fetch_stage_buffered.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the buffered fetch stage.
package fetch_pkg;

    localparam int          DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // One fetch-queue slot as decode sees it.
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] instr;
        logic [DEFAULT_XLEN-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; the head entry is read straight from storage.
module fetch_queue #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign doPop   = pop && !empty;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    overflow_check: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush))
        else $error("fetch_queue: push into full queue");

endmodule

// File: rtl/fetch_stage_buffered.sv
// Fetch stage: owns the PC, issues imem requests under a credit limit and queues
// returned instructions for decode, discarding responses orphaned by a redirect.
module fetch_stage_buffered
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            ValidD,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int SW = CW + 1;

    logic [XLEN-1:0]   pc;
    logic [CW-1:0]     outCnt;
    logic [CW-1:0]     dropCnt;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     tagCount;
    logic [2*XLEN-1:0] qHead;
    logic [XLEN-1:0]   tagHead;
    logic              qEmpty;
    logic              qFull;
    logic              tagEmpty;
    logic              tagFull;
    logic              pop;
    logic              issueOk;
    logic              reqFire;
    logic              rspKeep;

    assign pop = ValidD && !StallD;

    // Buffered plus in-flight words may never exceed the queue; a pop frees a slot this cycle.
    assign issueOk = !rst && !PCSrcE &&
                     (({1'b0, occ} + {1'b0, outCnt}) < (SW'(FQ_DEPTH) + SW'(pop)));

    assign imem_req_valid = issueOk;
    assign imem_req_addr  = pc;
    assign reqFire        = issueOk && imem_req_ready;
    assign rspKeep        = imem_rsp_valid && (dropCnt == '0) && !PCSrcE;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            outCnt  <= '0;
            dropCnt <= '0;
        end else begin
            outCnt <= outCnt + CW'(reqFire) - CW'(imem_rsp_valid);
            if (PCSrcE) begin
                pc      <= PCTargetE & ~XLEN'(3);
                dropCnt <= outCnt - CW'(imem_rsp_valid);
            end else begin
                if (reqFire) pc <= pc + XLEN'(4);
                if (imem_rsp_valid && (dropCnt != '0)) dropCnt <= dropCnt - CW'(1);
            end
        end
    end

    fetch_queue #(.WIDTH(2 * XLEN), .DEPTH(FQ_DEPTH)) instrQueue (
        .clk      (clk),
        .rst      (rst),
        .push     (rspKeep),
        .pushData ({imem_rsp_data, tagHead}),
        .pop      (pop),
        .flush    (PCSrcE),
        .popData  (qHead),
        .full     (qFull),
        .empty    (qEmpty),
        .count    (occ)
    );

    // Addresses of every outstanding request, discarded ones included, so tags stay aligned.
    fetch_queue #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) tagQueue (
        .clk      (clk),
        .rst      (rst),
        .push     (reqFire),
        .pushData (pc),
        .pop      (imem_rsp_valid),
        .flush    (1'b0),
        .popData  (tagHead),
        .full     (tagFull),
        .empty    (tagEmpty),
        .count    (tagCount)
    );

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        ValidD = !qEmpty;
        InstrD = XLEN'(NOP_INSTR);
        PCD    = '0;
        if (!qEmpty) begin
            InstrD = qHead[2*XLEN-1:XLEN];
            PCD    = qHead[XLEN-1:0];
        end
        PCPlus4D = PCD + XLEN'(4);
    end

    tag_tracks_outstanding: assert property (@(posedge clk) disable iff (rst)
        tagCount == outCnt);
    rsp_has_tag: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && tagEmpty));
    tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(reqFire && tagFull && !imem_rsp_valid));
    instr_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rspKeep && qFull && !pop));

endmodule

// File: tb/tb_fetch_stage_buffered.sv
// Bench: in-order variable-latency imem model, queue-level reference of the decode
// stream checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_fetch_stage_buffered;
    import fetch_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        StallD = 1'b0;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int minLat = 1;
    int maxLat = 1;
    int dropCnt = 0;
    mem_req_t    pending[$];
    fq_entry_t   modelQ[$];
    logic [31:0] modelPc = RST_PC;
    bit          rspOn = 1'b0;
    mem_req_t    rspCur;

    fetch_stage_buffered #(.XLEN(32), .RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .StallD         (StallD),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ValidD         (ValidD),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply one cycle of inputs just after the rising edge; the memory answers in order.
    task automatic stepCycle(input logic r, input logic br, input logic [31:0] tgt,
                             input logic st, input logic rdy);
        @(posedge clk);
        #1;
        cyc++;
        rst            = r;
        PCSrcE         = br;
        PCTargetE      = tgt;
        StallD         = st;
        imem_req_ready = rdy;
        if (!r && pending.size() > 0 && pending[0].due <= cyc) begin
            rspCur         = pending.pop_front();
            rspOn          = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = rspCur.data;
        end else begin
            rspOn          = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        repeat (2) stepCycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    // Reference: decode sees the model queue head; requests follow modelPc under the credit rule.
    always @(negedge clk) begin : cmp
        int        outCnt;
        bit        expValid;
        bit        popNow;
        bit        expReq;
        mem_req_t  nr;
        if (rst) begin
            check("req_valid_in_reset", 32'(imem_req_valid), 32'h0);
            pending.delete();
            modelQ.delete();
            dropCnt = 0;
            modelPc = RST_PC;
        end else begin
            outCnt   = pending.size() + (rspOn ? 1 : 0);
            expValid = modelQ.size() > 0;
            popNow   = expValid && !StallD;
            expReq   = !PCSrcE && (modelQ.size() + outCnt < DEPTH + (popNow ? 1 : 0));
            check("ValidD", 32'(ValidD), 32'(expValid));
            if (expValid) begin
                check("InstrD", InstrD, modelQ[0].instr);
                check("PCD", PCD, modelQ[0].pc);
                check("PCPlus4D", PCPlus4D, modelQ[0].pc + 32'd4);
            end else begin
                check("InstrD_nop", InstrD, NOP_INSTR);
                check("PCD_idle", PCD, 32'h0);
                check("PCPlus4D_idle", PCPlus4D, 32'h4);
            end
            check("req_valid", 32'(imem_req_valid), 32'(expReq));
            check("req_addr", imem_req_addr, modelPc);
            check("credit_bound", 32'(modelQ.size() + outCnt <= DEPTH), 32'h1);

            if (popNow) void'(modelQ.pop_front());
            if (PCSrcE) begin
                modelQ.delete();
                dropCnt = pending.size();
                modelPc = {PCTargetE[31:2], 2'b00};
            end else begin
                if (rspOn) begin
                    if (dropCnt > 0) dropCnt--;
                    else modelQ.push_back(fq_entry_t'{instr: rspCur.data, pc: rspCur.addr});
                end
                if (expReq && imem_req_ready) modelPc = modelPc + 32'd4;
            end

            if (imem_req_valid && imem_req_ready) begin
                nr.due  = cyc + int'($urandom_range(maxLat, minLat));
                if (pending.size() > 0 && nr.due <= pending[$].due) nr.due = pending[$].due + 1;
                nr.addr = imem_req_addr;
                nr.data = $urandom;
                pending.push_back(nr);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          seen;
        logic        r;
        logic        br;
        logic        st;
        logic        rdy;
        logic [31:0] tgt;

        // Start-up stream from RESET_PC with a 1-cycle memory.
        minLat = 1; maxLat = 1;
        doReset();
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("t1_reqv0", 32'(imem_req_valid), 32'h1);
        check("t1_addr0", imem_req_addr, 32'h100);
        check("t1_valid0", 32'(ValidD), 32'h0);
        check("t1_nop0", InstrD, 32'h0000_0013);
        check("t1_pcd0", PCD, 32'h0);
        check("t1_pc4_0", PCPlus4D, 32'h4);
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("t1_addr1", imem_req_addr, 32'h104);
        check("t1_valid1", 32'(ValidD), 32'h0);
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("t1_valid2", 32'(ValidD), 32'h1);
        check("t1_pcd2", PCD, 32'h100);
        check("t1_pc4_2", PCPlus4D, 32'h104);
        check("t1_addr2", imem_req_addr, 32'h108);
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("t1_pcd3", PCD, 32'h104);

        // Decode stall: output frozen, issue stops at the credit limit, nothing lost on release.
        doReset();
        run(6);
        for (int i = 0; i < 5; i++) begin
            stepCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); settle();
            check("stall_pcd", PCD, 32'h110);
            if (i >= 1) check("stall_no_issue", 32'(imem_req_valid), 32'h0);
        end
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("release_pcd0", PCD, 32'h110);
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("release_pcd1", PCD, 32'h114);
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("release_pcd2", PCD, 32'h118);

        // Reset while the queue is full.
        repeat (3) stepCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        stepCycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("rst_valid", 32'(ValidD), 32'h0);
        check("rst_nop", InstrD, 32'h0000_0013);
        check("rst_addr", imem_req_addr, 32'h100);
        check("rst_reqv", 32'(imem_req_valid), 32'h1);
        run(2); settle();
        check("rst_pcd", PCD, 32'h100);

        // Redirect with two responses in flight on a 3-cycle memory.
        minLat = 3; maxLat = 3;
        doReset();
        run(2);
        stepCycle(1'b0, 1'b1, 32'h16, 1'b0, 1'b1); settle();
        check("redir_inflight", 32'(pending.size()), 32'h2);
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("redir_addr", imem_req_addr, 32'h14);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
            if (ValidD) begin
                seen = 1'b1;
                check("redir_pcd", PCD, 32'h14);
            end
        end
        check("redir_seen", 32'(seen), 32'h1);

        // Memory not ready: address held, queue drains to NOP.
        minLat = 1; maxLat = 1;
        doReset();
        run(6);
        for (int i = 0; i < 4; i++) begin
            stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0); settle();
            check("rdy_low_addr", imem_req_addr, 32'h118);
            if (i >= 2) begin
                check("rdy_low_valid", 32'(ValidD), 32'h0);
                check("rdy_low_nop", InstrD, 32'h0000_0013);
            end
        end
        run(4);

        // PC wrap at the top of the address space; target low bits are ignored.
        stepCycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
        seen = imem_req_valid;
        for (int i = 0; i < 10 && !seen; i++) begin
            stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
            seen = imem_req_valid;
        end
        stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
        check("wrap_addr1", imem_req_addr, 32'h0);
        seen = ValidD;
        for (int i = 0; i < 10 && !seen; i++) begin
            stepCycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1); settle();
            seen = ValidD;
        end
        check("wrap_pcd", PCD, 32'hFFFF_FFFC);
        check("wrap_pc4", PCPlus4D, 32'h0);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                minLat = int'($urandom_range(2, 1));
                maxLat = minLat + int'($urandom_range(3, 0));
            end
            r   = ($urandom_range(199, 0) == 0);
            br  = ($urandom_range(19, 0) == 0);
            tgt = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            st  = ($urandom_range(9, 0) < 3);
            rdy = ($urandom_range(9, 0) < 7);
            stepCycle(r, br, tgt, st, rdy);
        end
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
